volcado_banco_reg: RTL and testbench

VOLCADO_BANCO_REG -- requirements
Module: volcado_banco_reg

---
 rtl/volcado_banco_reg.sv | 217 +++++++++++++++++++++
 tb/tb_volcado_banco_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/volcado_banco_reg.sv
// -----------------------------------------------------------------------------
// volcado_banco_reg
//
// Dumps a contiguous range of a 32x32 register bank, FIRST_ADDR..LAST_ADDR, as
// a stream of valid/ready words. Each word takes one READ cycle, in which RA
// addresses the bank and DR is captured, followed by a SEND cycle that holds
// the word until it is accepted. With dout_ready tied high this gives one word
// every two cycles. The block only drives the read port and never writes the
// bank.
//
// Optional feature, selected with the macro VOLCADO_CHECKSUM_EN:
//   When the macro is defined, the block XORs every accepted data word into a
//   32-bit checksum. A CHK state then sends the checksum as the final word,
//   with dout_addr = 0 and dout_last = 1. In that build the LAST_ADDR data
//   word has dout_last = 0.
//
// Parameters:
//   FIRST_ADDR  first register dumped (0..31)
//   LAST_ADDR   last register dumped (FIRST_ADDR..31)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   start       begin a dump (sampled only in IDLE)
//   RA          bank read address
//   DR          bank read data for RA (combinational)
//   dout        dumped word
//   dout_addr   register address of dout (0 for the checksum word)
//   dout_valid  dout/dout_addr/dout_last valid
//   dout_ready  downstream accepts the word
//   dout_last   final word of the dump
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module volcado_banco_reg #(
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  RA,
    input  logic [31:0] DR,
    output logic [31:0] dout,
    output logic [4:0]  dout_addr,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic        done
);

`ifdef VOLCADO_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        DONE = 3'd4
    } state_t;
`endif

    localparam logic [4:0] FIRST_A = 5'(FIRST_ADDR);
    localparam logic [4:0] LAST_A  = 5'(LAST_ADDR);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  ra_q, ra_d;
    logic [31:0] dout_q, dout_d;
    logic [4:0]  dout_addr_q, dout_addr_d;
    logic        dout_valid_q, dout_valid_d;
    logic        dout_last_q, dout_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef VOLCADO_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic at_last;
    assign at_last = (cnt_q == LAST_A);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ra_d         = ra_q;
        dout_d       = dout_q;
        dout_addr_d  = dout_addr_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef VOLCADO_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    // RA is loaded together with the counter so that it is
                    // already correct during the READ cycle.
                    cnt_d   = FIRST_A;
                    ra_d    = FIRST_A;
                    busy_d  = 1'b1;
                    state_d = READ;
`ifdef VOLCADO_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            READ: begin
                dout_d       = DR;
                dout_addr_d  = cnt_q;
                dout_valid_d = 1'b1;
`ifdef VOLCADO_CHECKSUM_EN
                dout_last_d  = 1'b0;
`else
                dout_last_d  = at_last;
`endif
                state_d      = SEND;
            end
            SEND: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
`ifdef VOLCADO_CHECKSUM_EN
                    csum_d       = csum_q ^ dout_q;
`endif
                    if (!at_last) begin
                        cnt_d   = 5'(cnt_q + 5'd1);
                        ra_d    = 5'(cnt_q + 5'd1);
                        state_d = READ;
                    end else begin
`ifdef VOLCADO_CHECKSUM_EN
                        // The checksum word includes the word accepted in
                        // this cycle, so the XOR is folded in directly here.
                        dout_d       = csum_q ^ dout_q;
                        dout_addr_d  = '0;
                        dout_valid_d = 1'b1;
                        dout_last_d  = 1'b1;
                        state_d      = CHK;
`else
                        done_d       = 1'b1;
                        state_d      = DONE;
`endif
                    end
                end
            end
`ifdef VOLCADO_CHECKSUM_EN
            CHK: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end
            end
`endif
            DONE: begin
                // start is deliberately ignored here. A new dump can only be
                // accepted once the FSM is back in IDLE.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d       = 1'b0;
                dout_valid_d = 1'b0;
                dout_last_d  = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ra_q         <= '0;
            dout_q       <= '0;
            dout_addr_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef VOLCADO_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ra_q         <= ra_d;
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef VOLCADO_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign RA         = ra_q;
    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_volcado_banco_reg.sv
// Directed bench for volcado_banco_reg. It uses three instances:
//   0: default range 0..31, bank reg[i] = i*0x11111111
//   1: single-register range 31..31
//   2: range 2..4 with a hand-picked bank (2:A5A5A5A5 3:0F0F0F0F 4:FFFF0000)
// The expected checksum for instance 2 is
// A5A5A5A5 ^ 0F0F0F0F ^ FFFF0000 = 5555AAAA.
module tb_volcado_banco_reg;

`ifdef VOLCADO_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start, ready, valid, last, busy, done;
    logic [4:0]  ra[3];
    logic [4:0]  dout_addr[3];
    logic [31:0] dr[3];
    logic [31:0] dout[3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] bankv(input int s, input int a);
        if (s == 2) begin
            case (a)
                2:       return 32'hA5A5_A5A5;
                3:       return 32'h0F0F_0F0F;
                4:       return 32'hFFFF_0000;
                default: return 32'h0;
            endcase
        end
        return 32'(a * 32'h1111_1111);
    endfunction

    assign dr[0] = bankv(0, int'(ra[0]));
    assign dr[1] = bankv(1, int'(ra[1]));
    assign dr[2] = bankv(2, int'(ra[2]));

    volcado_banco_reg #(.FIRST_ADDR(0), .LAST_ADDR(31)) u_full (
        .clk(clk), .rst(rst), .start(start[0]), .RA(ra[0]), .DR(dr[0]),
        .dout(dout[0]), .dout_addr(dout_addr[0]), .dout_valid(valid[0]),
        .dout_ready(ready[0]), .dout_last(last[0]), .busy(busy[0]), .done(done[0]));

    volcado_banco_reg #(.FIRST_ADDR(31), .LAST_ADDR(31)) u_one (
        .clk(clk), .rst(rst), .start(start[1]), .RA(ra[1]), .DR(dr[1]),
        .dout(dout[1]), .dout_addr(dout_addr[1]), .dout_valid(valid[1]),
        .dout_ready(ready[1]), .dout_last(last[1]), .busy(busy[1]), .done(done[1]));

    volcado_banco_reg #(.FIRST_ADDR(2), .LAST_ADDR(4)) u_sum (
        .clk(clk), .rst(rst), .start(start[2]), .RA(ra[2]), .DR(dr[2]),
        .dout(dout[2]), .dout_addr(dout_addr[2]), .dout_valid(valid[2]),
        .dout_ready(ready[2]), .dout_last(last[2]), .busy(busy[2]), .done(done[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = '0;
        ready = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one dump on instance s. It checks latency, hold-while-stalled, word
    // order and content, the done pulse, and the return to IDLE.
    // mode 0: ready always 1; mode 1: ready pattern 1,0,0.
    // hold:   keep start high through the dump, then check the restart from IDLE.
    task automatic run_dump(input int s, input int first, input int lst,
                            input int mode, input bit hold);
        int ndata, nw, idx;
        logic [31:0] xs, exp_d, pd;
        logic [4:0]  exp_a, pa;
        logic        exp_l, pv, pr, pl;
        bit          fin;
        ndata = lst - first + 1;
        nw    = ndata + CS;
        idx   = 0;
        xs    = '0;
        pv    = 1'b0;
        pr    = 1'b0;
        pd    = '0;
        pa    = '0;
        pl    = 1'b0;
        fin   = 1'b0;
        for (int a = first; a <= lst; a++) xs ^= bankv(s, a);
        @(negedge clk);
        chk("idle_busy", 32'(busy[s]), 32'd0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 1) begin
                chk("lat_c1_valid", 32'(valid[s]), 32'd0);
                chk("lat_c1_busy", 32'(busy[s]), 32'd1);
                chk("lat_c1_ra", 32'(ra[s]), 32'(first));
            end
            if (cyc == 2) chk("lat_c2_valid", 32'(valid[s]), 32'd1);
            if (pv && !pr) begin
                chk("hold_valid", 32'(valid[s]), 32'd1);
                chk("hold_data", dout[s], pd);
                chk("hold_addr", 32'(dout_addr[s]), 32'(pa));
                chk("hold_last", 32'(last[s]), 32'(pl));
            end
            if (done[s]) begin
                chk("done_words", 32'(idx), 32'(nw));
                fin = 1'b1;
            end
            start[s] = hold || (cyc == 0);
            ready[s] = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (valid[s] && ready[s]) begin
                chk("word_in_range", 32'(idx < nw), 32'd1);
                if (idx < ndata) begin
                    exp_a = 5'(first + idx);
                    exp_d = bankv(s, first + idx);
                    exp_l = (idx == ndata - 1) && (CS == 0);
                    chk("ra_hold", 32'(ra[s]), 32'(exp_a));
                end else begin
                    exp_a = '0;
                    exp_d = xs;
                    exp_l = 1'b1;
                end
                chk("word_addr", 32'(dout_addr[s]), 32'(exp_a));
                chk("word_data", dout[s], exp_d);
                chk("word_last", 32'(last[s]), 32'(exp_l));
                idx++;
            end
            pv = valid[s];
            pr = ready[s];
            pd = dout[s];
            pa = dout_addr[s];
            pl = last[s];
        end
        chk("dump_done_seen", 32'(fin), 32'd1);
        @(negedge clk);
        chk("post_busy", 32'(busy[s]), 32'd0);
        chk("post_valid", 32'(valid[s]), 32'd0);
        chk("post_done_once", 32'(done[s]), 32'd0);
        if (hold) begin
            // start was high during DONE (ignored); it is still high in IDLE
            @(negedge clk);
            chk("restart_busy", 32'(busy[s]), 32'd1);
            chk("restart_ra", 32'(ra[s]), 32'(first));
            do_reset();
        end else begin
            start[s] = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        int vcount;
        rst   = 1'b1;
        start = '0;
        ready = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_last", 32'(last[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_dout", dout[0], 32'd0);
        chk("rst_addr", 32'(dout_addr[0]), 32'd0);
        chk("rst_ra", 32'(ra[0]), 32'd0);
        rst = 1'b0;

        run_dump(0, 0, 31, 0, 1'b0);
        run_dump(0, 0, 31, 1, 1'b0);

        // Abort mid-dump while word 10 is presented (and stalled).
        @(negedge clk);
        start[0] = 1'b1;
        ready[0] = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (valid[0] && dout_addr[0] == 5'd10) found = 1'b1;
        end
        chk("abort_reached_10", 32'(found), 32'd1);
        ready[0] = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ready[0] = 1'b1;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_valid", 32'(valid[0]), 32'd0);
        chk("abort_ra", 32'(ra[0]), 32'd0);
        chk("abort_dout", dout[0], 32'd0);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid[0] || busy[0]) vcount++;
        end
        chk("abort_quiet", 32'(vcount), 32'd0);
        run_dump(0, 0, 31, 0, 1'b0);

        run_dump(0, 0, 31, 0, 1'b1);
        run_dump(1, 31, 31, 0, 1'b0);
        run_dump(2, 2, 4, 1, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst      = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start[0] = 1'b0;
        chk("rst_prio_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("rst_prio_stay", 32'(busy[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
